ifetch_stage: RTL

- Instruction-fetch stage directly downstream of the PC generator.
- Accepts one PC per valid/ready handshake, issues a single outstanding read to the instruction cache, and buffers the returned 32-bit instruction.
- Presents the instruction plus its PC to decode over a valid/ready handshake.
- Supports flush (drop in-flight work, including a cache response still owed) and detects misaligned PCs without touching the cache.

---
 rtl/ifetch_stage_if.sv | 35 +++
 rtl/ifetch_stage.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ifetch_stage_if.sv
// Bundle of every handshake and bus signal around the instruction-fetch stage.
// The slave modport is the fetch stage view; master is the surrounding pipeline/cache view.
interface ifetch_stage_if #(
   parameter int XLEN = 64,
   parameter int ILEN = 32
);
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic            fetch_i_ready;
   logic            icache_req_valid;
   logic [XLEN-1:0] icache_req_addr;
   logic            icache_req_ready;
   logic            icache_resp_valid;
   logic [ILEN-1:0] icache_resp_data;
   logic            decode_ready;
   logic            inst_valid;
   logic [ILEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic            inst_misalign;
   logic            flush;

   modport slave (
      input  pc, pc_valid, icache_req_ready, icache_resp_valid, icache_resp_data,
             decode_ready, flush,
      output fetch_i_ready, icache_req_valid, icache_req_addr, inst_valid, inst,
             inst_pc, inst_misalign
   );

   modport master (
      output pc, pc_valid, icache_req_ready, icache_resp_valid, icache_resp_data,
             decode_ready, flush,
      input  fetch_i_ready, icache_req_valid, icache_req_addr, inst_valid, inst,
             inst_pc, inst_misalign
   );
endinterface

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: one outstanding icache read, a one-entry instruction buffer
// toward decode, flush with drain of an owed response, and misaligned-PC fault entries.
module ifetch_stage_chk (
   input logic clk,
   input logic rst,
   input logic resp_valid_i,
   input logic resp_expected_i
);
   // A cache response is only legal while a read is owed to this stage.
   a_resp_owed: assert property (@(posedge clk) disable iff (rst)
      resp_valid_i |-> resp_expected_i)
      else $error("icache response with no outstanding request");
endmodule

module ifetch_stage #(
   parameter int XLEN = 64,
   parameter int ILEN = 32
) (
   input logic           clk,
   input logic           rst,
   ifetch_stage_if.slave bus
);
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic [ILEN-1:0] inst_q, inst_d;
   logic            mis_q, mis_d;
   logic            fetch_ready_s;
   logic            accept_s;
   logic            misaligned_s;

   assign fetch_ready_s = !bus.flush &&
                          ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.decode_ready));
   assign accept_s      = bus.pc_valid && fetch_ready_s;
   assign misaligned_s  = (bus.pc[1:0] != 2'b00);

   // Next-state and buffer-update logic; flush outranks every other transition.
   always_comb begin
      state_d   = state_q;
      req_pc_d  = req_pc_q;
      inst_pc_d = inst_pc_q;
      inst_d    = inst_q;
      mis_d     = mis_q;
      if (bus.flush) begin
         // A read the cache has accepted but not answered must be drained before reuse.
         case (state_q)
            ST_REQ:   state_d = bus.icache_req_ready  ? ST_DRAIN : ST_IDLE;
            ST_WAIT:  state_d = bus.icache_resp_valid ? ST_IDLE  : ST_DRAIN;
            ST_DRAIN: state_d = bus.icache_resp_valid ? ST_IDLE  : ST_DRAIN;
            default:  state_d = ST_IDLE;
         endcase
      end else if (accept_s) begin
         req_pc_d = bus.pc;
         if (misaligned_s) begin
            state_d   = ST_HOLD;
            inst_d    = {ILEN{1'b0}};
            inst_pc_d = bus.pc;
            mis_d     = 1'b1;
         end else begin
            state_d = ST_REQ;
         end
      end else begin
         case (state_q)
            ST_REQ: begin
               if (bus.icache_req_ready) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (bus.icache_resp_valid) begin
                  state_d   = ST_HOLD;
                  inst_d    = bus.icache_resp_data;
                  inst_pc_d = req_pc_q;
                  mis_d     = 1'b0;
               end else begin
                  state_d = ST_WAIT;
               end
            end
            ST_HOLD: begin
               if (bus.decode_ready) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            ST_DRAIN: begin
               if (bus.icache_resp_valid) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         req_pc_q  <= {XLEN{1'b0}};
         inst_pc_q <= {XLEN{1'b0}};
         inst_q    <= {ILEN{1'b0}};
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_pc_q  <= req_pc_d;
         inst_pc_q <= inst_pc_d;
         inst_q    <= inst_d;
         mis_q     <= mis_d;
      end
   end

   assign bus.fetch_i_ready    = fetch_ready_s;
   assign bus.icache_req_valid = (state_q == ST_REQ);
   assign bus.icache_req_addr  = req_pc_q;
   assign bus.inst_valid       = (state_q == ST_HOLD);
   assign bus.inst             = inst_q;
   assign bus.inst_pc          = inst_pc_q;
   assign bus.inst_misalign    = mis_q;

   ifetch_stage_chk u_chk (
      .clk             (clk),
      .rst             (rst),
      .resp_valid_i    (bus.icache_resp_valid),
      .resp_expected_i ((state_q == ST_WAIT) || (state_q == ST_DRAIN))
   );
endmodule
